// File: rtl/learning_neuron.sv
// Trainable linear neuron: N fixed-point inputs with per-input weights and a bias.
// Combinational forward/backprop paths; online gradient-descent weight update every clock.
module learning_neuron #(
   parameter int N    = 32,
   parameter int DW   = 16,
   parameter int FRAC = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N*DW-1:0]   x,
   input  logic [N-1:0]      enabled,
   input  logic [DW-1:0]     err_in,
   input  logic [DW-1:0]     target,
   input  logic              use_target,
   input  logic [DW-1:0]     lr,
   output logic [N*DW-1:0]   back,
   output logic [DW-1:0]     out,
   output logic [DW-1:0]     err
);

   // Wide enough for the full sum of N products plus the shifted bias without overflow.
   localparam int AW = 2*DW + $clog2(N) + 1;

   // Clamp a wide signed value into DW bits.
   function automatic logic [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
      logic [DW-1:0] r;
      if ((&v[AW-1:DW-1]) || !(|v[AW-1:DW-1])) begin
         r = v[DW-1:0];
      end else if (v[AW-1]) begin
         r = {1'b1, {(DW-1){1'b0}}};
      end else begin
         r = {1'b0, {(DW-1){1'b1}}};
      end
      return r;
   endfunction

   logic signed [DW-1:0] w_r [N];
   logic signed [DW-1:0] bias_r;
   logic signed [DW-1:0] w_nxt_s [N];
   logic signed [DW-1:0] bias_nxt_s;
   logic signed [AW-1:0] acc_s;
   logic signed [AW-1:0] diff_s;
   logic signed [DW-1:0] out_s;
   logic signed [DW-1:0] err_s;
   logic signed [DW-1:0] g_s;

   // Forward pass: masked dot product plus bias, rescaled and saturated.
   always_comb begin
      acc_s = AW'(bias_r) <<< FRAC;
      for (int i = 0; i < N; i++) begin
         acc_s = acc_s + (enabled[i] ? (AW'($signed(x[i*DW +: DW])) * AW'(w_r[i]))
                                     : {AW{1'b0}});
      end
      out_s = sat_dw(acc_s >>> FRAC);
   end

   // Effective error: output-layer error or the error handed back from downstream.
   always_comb begin
      diff_s = AW'($signed(target)) - AW'(out_s);
      if (use_target) begin
         err_s = sat_dw(diff_s);
      end else begin
         err_s = $signed(err_in);
      end
   end

   // Backprop terms use the pre-update weights.
   always_comb begin
      back = {(N*DW){1'b0}};
      for (int i = 0; i < N; i++) begin
         if (enabled[i]) begin
            back[i*DW +: DW] = sat_dw((AW'(err_s) * AW'(w_r[i])) >>> FRAC);
         end else begin
            back[i*DW +: DW] = {DW{1'b0}};
         end
      end
   end

   // Gradient step: scaled error applied to each enabled weight and to the bias.
   always_comb begin
      g_s        = sat_dw((AW'($signed(lr)) * AW'(err_s)) >>> FRAC);
      bias_nxt_s = sat_dw(AW'(bias_r) + AW'(g_s));
      for (int i = 0; i < N; i++) begin
         if (enabled[i]) begin
            w_nxt_s[i] = sat_dw(AW'(w_r[i]) +
                                ((AW'(g_s) * AW'($signed(x[i*DW +: DW]))) >>> FRAC));
         end else begin
            w_nxt_s[i] = w_r[i];
         end
      end
   end

   assign out = out_s;
   assign err = err_s;

   // Weight and bias registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            w_r[i] <= {DW{1'b0}};
         end
         bias_r <= {DW{1'b0}};
      end else begin
         for (int i = 0; i < N; i++) begin
            w_r[i] <= w_nxt_s[i];
         end
         bias_r <= bias_nxt_s;
      end
   end

endmodule

// File: tb/tb_learning_neuron.sv
// Directed and randomized checks of learning_neuron against an integer reference model.
module tb_learning_neuron;
   localparam int N  = 32;
   localparam int DW = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N*DW-1:0]   x;
   logic [N-1:0]      enabled;
   logic [DW-1:0]     err_in, target, lr;
   logic              use_target;
   logic [N*DW-1:0]   back;
   logic [DW-1:0]     out, err;

   int tests = 0;
   int fails = 0;

   longint          mw [N];
   longint          mbias;
   longint          mout, merr;
   logic [N*DW-1:0] mback;
   logic [N*DW-1:0] exp_bus;

   learning_neuron dut (
      .clk(clk), .rst_n(rst_n), .x(x), .enabled(enabled), .err_in(err_in),
      .target(target), .use_target(use_target), .lr(lr),
      .back(back), .out(out), .err(err)
   );

   always #5 clk = ~clk;

   function automatic longint sat(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic longint sx(input logic [DW-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint xi(input int i);
      return sx(x[i*DW +: DW]);
   endfunction

   task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) mw[i] = 0;
      mbias = 0;
   endtask

   task automatic model_eval();
      longint acc;
      acc = mbias * 256;
      for (int i = 0; i < N; i++) if (enabled[i]) acc += xi(i) * mw[i];
      mout = sat(acc >>> 8);
      merr = use_target ? sat(sx(target) - mout) : sx(err_in);
      for (int i = 0; i < N; i++)
         mback[i*DW +: DW] = enabled[i] ? 16'(sat((merr * mw[i]) >>> 8)) : 16'h0000;
   endtask

   task automatic model_update();
      longint g;
      model_eval();
      g = sat((sx(lr) * merr) >>> 8);
      for (int i = 0; i < N; i++) if (enabled[i]) mw[i] = sat(mw[i] + ((g * xi(i)) >>> 8));
      mbias = sat(mbias + g);
   endtask

   task automatic check_model(input string tag);
      model_eval();
      chk({tag, "_out"}, {{(N*DW-DW){1'b0}}, out}, {{(N*DW-DW){1'b0}}, 16'(mout)});
      chk({tag, "_err"}, {{(N*DW-DW){1'b0}}, err}, {{(N*DW-DW){1'b0}}, 16'(merr)});
      chk({tag, "_back"}, back, mback);
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_x();
      for (int i = 0; i < N; i++) x[i*DW +: DW] = 16'($urandom);
   endtask

   initial begin
      // Reset with arbitrary inputs
      rst_n = 1'b0; rand_x(); lr = 16'($urandom); enabled = '1;
      use_target = 1'b1; target = 16'h1234; err_in = 16'h0000;
      model_reset();
      #3;
      chk("rst_out", {{(N*DW-DW){1'b0}}, out}, '0);
      chk("rst_back", back, '0);
      chk("rst_err", {{(N*DW-DW){1'b0}}, err}, {{(N*DW-DW){1'b0}}, 16'h1234});
      @(negedge clk); rst_n = 1'b1; lr = 16'h0000;
      step();
      chk("lr0_out", {{(N*DW-DW){1'b0}}, out}, '0);
      check_model("lr0");

      // Online learning on input 0
      x = '0; enabled = 32'h1; lr = 16'h0100;
      for (int k = 0; k < 6; k++) begin
         x[15:0] = (k % 2 == 0) ? 16'h0100 : 16'h0000;
         target  = x[15:0];
         #1;
         if (k == 0) begin
            chk("learn1_out", {{(N*DW-DW){1'b0}}, out}, {{(N*DW-DW){1'b0}}, 16'h0000});
            chk("learn1_err", {{(N*DW-DW){1'b0}}, err}, {{(N*DW-DW){1'b0}}, 16'h0100});
         end else if (k == 1) begin
            chk("learn2_out", {{(N*DW-DW){1'b0}}, out}, {{(N*DW-DW){1'b0}}, 16'h0100});
            chk("learn2_err", {{(N*DW-DW){1'b0}}, err}, {{(N*DW-DW){1'b0}}, 16'hFF00});
         end else begin
            chk("learnN_out", {{(N*DW-DW){1'b0}}, out}, {{(N*DW-DW){1'b0}}, target});
            chk("learnN_err", {{(N*DW-DW){1'b0}}, err}, '0);
         end
         check_model("learn");
         step();
      end

      // Enable mask: teach w1, then disable input 0
      enabled = 32'h2; x = '0; x[31:16] = 16'h0100; target = 16'h0100;
      step();
      x[15:0] = 16'h0200; x[31:16] = 16'h0200; lr = 16'h0000; target = 16'h0000; #1;
      chk("mask_out", {{(N*DW-DW){1'b0}}, out}, {{(N*DW-DW){1'b0}}, 16'h0300});
      chk("mask_back0", {{(N*DW-DW){1'b0}}, back[15:0]}, '0);
      check_model("mask");
      lr = 16'h0010;
      step();
      enabled = 32'h1; lr = 16'h0000; #1;
      chk("mask_w0_held", {{(N*DW-DW){1'b0}}, out}, {{(N*DW-DW){1'b0}}, 16'h02D0});
      check_model("mask2");

      // Backprop from a downstream error
      x = '0; x[15:0] = 16'h0100; use_target = 1'b0; err_in = 16'h0100; lr = 16'h0100;
      step();
      err_in = 16'h0080; lr = 16'h0000; #1;
      chk("bp_back0", {{(N*DW-DW){1'b0}}, back[15:0]}, {{(N*DW-DW){1'b0}}, 16'h0100});
      check_model("bp");
      step();
      chk("bp_back0_hold", {{(N*DW-DW){1'b0}}, back[15:0]}, {{(N*DW-DW){1'b0}}, 16'h0100});

      // Saturation: drive every weight to the positive rail
      for (int i = 0; i < N; i++) x[i*DW +: DW] = 16'h7FFF;
      enabled = '1; err_in = 16'h7FFF; lr = 16'h7FFF;
      for (int k = 0; k < 3; k++) step();
      lr = 16'h0000; err_in = 16'h0100; #1;
      for (int i = 0; i < N; i++) exp_bus[i*DW +: DW] = 16'h7FFF;
      chk("sat_out", {{(N*DW-DW){1'b0}}, out}, {{(N*DW-DW){1'b0}}, 16'h7FFF});
      chk("sat_back_pos", back, exp_bus);
      check_model("sat");
      err_in = 16'h8000; #1;
      for (int i = 0; i < N; i++) exp_bus[i*DW +: DW] = 16'h8000;
      chk("sat_back_neg", back, exp_bus);
      err_in = 16'h7FFF; lr = 16'h7FFF;
      step();
      lr = 16'h0000; err_in = 16'h0100; #1;
      for (int i = 0; i < N; i++) exp_bus[i*DW +: DW] = 16'h7FFF;
      chk("sat_nowrap", back, exp_bus);

      // Randomized learning against the reference model
      for (int k = 0; k < 150; k++) begin
         rand_x();
         enabled    = 32'($urandom);
         use_target = 1'($urandom);
         target     = 16'($urandom);
         err_in     = 16'($urandom_range(0, 1023)) - 16'd512;
         lr         = 16'($urandom_range(0, 48));
         #1;
         check_model("rand");
         step();
      end

      // Asynchronous reset between edges
      rand_x(); enabled = '1; use_target = 1'b1; target = 16'h0040; lr = 16'h0020;
      #2; rst_n = 1'b0; model_reset(); #1;
      chk("arst_out", {{(N*DW-DW){1'b0}}, out}, '0);
      chk("arst_back", back, '0);
      check_model("arst");
      @(negedge clk); rst_n = 1'b1; #1;
      check_model("arst_rel");
      step();
      check_model("arst_learn");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/learning_neuron.md
Name: learning_neuron

Overview:
- Single trainable linear neuron with 32 inputs, 32 per-input weights plus a bias, and online gradient-descent learning.
- Forward output and backpropagated error terms are combinational; weights update once per clock.
- An integrated "backprop start" stage forms the output-layer error (target − out) when the neuron is last in the chain. Otherwise an error from the downstream layer is used.
- Fixed-point replacement for the behavioural real-valued neuron.

Parameters:
N, 32, number of inputs (and per-input weights).
DW, 16, signed fixed-point word width of all data, weights, errors and rate.
FRAC, 8, fractional bits (Q7.8 at defaults; 1.0 = 0x0100).

Ports:
clk  in  1  clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
x  in  N*DW  inputs; x[i] = bits [i*DW +: DW], signed.
enabled  in  N  per-input enable mask; disabled inputs contribute nothing and do not learn.
err_in  in  DW  downstream backprop error (used when use_target=0).
target  in  DW  expected output (used when use_target=1).
use_target  in  1  1 = output-layer mode: err = target − out.
lr  in  DW  learning rate, signed fixed point; 0 freezes learning.
back  out  N*DW  per-input backprop error terms back[i].
out  out  DW  neuron output.
err  out  DW  effective error used for the update (observability).

Behaviour:
- State: w[0..N-1] and bias, each DW bits signed, registered.
- Reset (rst_n=0, async): all w[i]=0, bias=0. Consequently out=0 and back=0 while inputs are held.
- Forward, combinational:
  - p_i = enabled[i] ? x[i]*w[i] : 0, full 2*DW-bit product.
  - acc = Σp_i + (bias << FRAC), with width 2*DW+log2(N)+1 and no intermediate overflow.
  - out = sat_DW(acc >>> FRAC).
  - Activation is identity, so derivative = 1.
- sat_DW clamps to [−2^(DW−1), 2^(DW−1)−1]; all shifts are arithmetic (truncate toward −inf).
- Error, combinational:
  - err = use_target ? sat_DW(target − out) : err_in.
  - target − out is computed at DW+1 bits before saturation.
- Backprop, combinational: back[i] = enabled[i] ? sat_DW((err*w[i]) >>> FRAC) : 0, using current (pre-update) weights.
- Update, each rising clk when rst_n=1:
  - g = sat_DW((lr*err) >>> FRAC).
  - w[i] <= enabled[i] ? sat_DW(w[i] + ((g*x[i]) >>> FRAC)) : w[i].
  - bias <= sat_DW(bias + g).
  - The sum is formed at DW+1 bits, then saturated.
- Latency:
  - out, err and back respond in zero cycles to x, target, err_in, enabled, lr.
  - Weight changes are visible one edge after the error is presented.
- No handshake: the neuron learns every cycle. Hold lr=0 to freeze weights (inference mode).
- Reset asserted mid-operation clears weights immediately, independent of clk. Deassertion takes effect at the next edge.
- All-zero enabled: out = bias. back is all 0; only bias learns.
- Saturation boundaries:
  - Positive overflow yields 0x7FFF and negative overflow yields 0x8000 on out, back, and the weight/bias updates.
  - Weights never wrap.

Test Plan:
1. Reset: assert rst_n=0 with arbitrary x and lr, release → out=0, back=0, err=target when use_target=1. An edge with lr=0 leaves weights unchanged.
2. Online learning: use_target=1, lr=0x0100, enabled=0x1, alternate x[0]=0x0100/target=0x0100 and x[0]=0/target=0. Required values:
   - Cycle 1: out=0, err=0x0100; then w0=0x0100, bias=0x0100.
   - Cycle 2: out=0x0100, err=0xFF00; then bias=0.
   - Cycle 3 onward: out=target, err=0, weights stable.
3. Enable mask: w0=w1=0x0100 after learning, x[0]=x[1]=0x0200, enabled=0x2 → out=0x0200+bias. back[0]=0 and w0 unchanged across an update edge.
4. Backprop: use_target=0, err_in=0x0080, w0=0x0200 → back[0]=0x0100. With lr=0 the weights are unchanged.
5. Saturation: drive weights to 0x7FFF via repeated large positive error, and x all 0x7FFF enabled → out=0x7FFF. Weights hold at 0x7FFF, with no wrap to negative.
6. Async reset mid-learning: pulse rst_n low between edges → weights and bias are 0 immediately, out=0 before the next edge.
